// File: rtl/noc_pe_inject_arb_if.sv
// ---------------------------------------------------------------------------
// noc_pe_inject_arb_if
// Bundles the requester side and the switch PE-port side of the injection
// arbiter into one interface.
//   master : the environment (PE cluster requesters + switch PE input)
//   slave  : the arbiter itself
// Signals
//   i_valid    [N_SRC]             per-requester valid
//   i_data     [N_SRC*data_width]  payload, requester k at [k*data_width +: data_width]
//   i_dest_x   [N_SRC*x_size]      destination x per requester
//   i_dest_y   [N_SRC*y_size]      destination y per requester
//   o_ready    [N_SRC]             one-hot accept strobe (combinational)
//   o_valid_pe                     flit valid to switch PE input
//   o_data_pe  [total_width]       flit {payload, dest_y, dest_x}
//   i_ready_pe                     switch PE-port ready
//   o_grant_id [ID_W]              requester whose flit sits in o_data_pe
// ---------------------------------------------------------------------------
interface noc_pe_inject_arb_if #(
  parameter int N_SRC       = 4,
  parameter int data_width  = 32,
  parameter int x_size      = 1,
  parameter int y_size      = 1,
  parameter int total_width = x_size + y_size + data_width,
  parameter int ID_W        = $clog2(N_SRC)
) ();
  logic [N_SRC-1:0]            i_valid;
  logic [N_SRC*data_width-1:0] i_data;
  logic [N_SRC*x_size-1:0]     i_dest_x;
  logic [N_SRC*y_size-1:0]     i_dest_y;
  logic [N_SRC-1:0]            o_ready;
  logic                        o_valid_pe;
  logic [total_width-1:0]      o_data_pe;
  logic                        i_ready_pe;
  logic [ID_W-1:0]             o_grant_id;

  modport master (
    output i_valid, i_data, i_dest_x, i_dest_y, i_ready_pe,
    input  o_ready, o_valid_pe, o_data_pe, o_grant_id
  );

  modport slave (
    input  i_valid, i_data, i_dest_x, i_dest_y, i_ready_pe,
    output o_ready, o_valid_pe, o_data_pe, o_grant_id
  );
endinterface

// File: rtl/noc_pe_inject_arb.sv
// ---------------------------------------------------------------------------
// noc_pe_inject_arb
// Shares the single PE injection port of a mesh switch among N_SRC local
// requesters. The round-robin winner's request is packed into a flit
// {payload, dest_y, dest_x} and held in a one-entry output register until the
// switch accepts it. A new flit can be loaded in the same cycle the held one
// drains, so throughput is one flit per cycle while the switch is ready.
// Ports
//   clk  : clock, all flops on posedge
//   rst  : asynchronous active-high reset
//   bus  : noc_pe_inject_arb_if.slave (requester and PE-port handshakes)
//   o_pkt_cnt / o_stall_cnt : 32-bit saturating statistics, present only
//                             when NOC_INJ_STATS_EN is defined
// Configuration macro: NOC_INJ_STATS_EN
// ---------------------------------------------------------------------------
module noc_pe_inject_arb #(
  parameter int N_SRC       = 4,
  parameter int data_width  = 32,
  parameter int x_size      = 1,
  parameter int y_size      = 1,
  parameter int total_width = x_size + y_size + data_width,
  parameter int ID_W        = $clog2(N_SRC)
) (
  input  logic                    clk,
  input  logic                    rst,
  noc_pe_inject_arb_if.slave      bus
`ifdef NOC_INJ_STATS_EN
  ,
  output logic [31:0]             o_pkt_cnt,
  output logic [31:0]             o_stall_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                 state_r;
  logic                   valid_r;
  logic [total_width-1:0] data_r;
  logic [ID_W-1:0]        grant_r;
  logic [ID_W-1:0]        ptr_r;

  logic                   load_s;
  logic                   win_found_s;
  logic [ID_W-1:0]        win_idx_s;
  logic [ID_W-1:0]        ptr_next_s;
  logic [total_width-1:0] flit_s;
  logic [N_SRC-1:0]       ready_s;

  // Requester index reached by stepping 'off' places from 'base', wrapping at N_SRC.
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_SRC) begin
      sum = sum - N_SRC;
    end else begin
      sum = sum;
    end
    return sum[ID_W-1:0];
  endfunction

  // The buffer can take a new flit when empty or when the held flit drains
  // this cycle; nothing is granted while reset is asserted.
  assign load_s = ~rst & ((state_r == ST_EMPTY) | bus.i_ready_pe);

  // Round-robin search: first valid requester starting at the pointer.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!win_found_s && bus.i_valid[rr_idx(ptr_r, i)]) begin
        win_found_s = 1'b1;
        win_idx_s   = rr_idx(ptr_r, i);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Pack the winner's request into a flit and compute the post-grant pointer.
  always_comb begin
    flit_s = {bus.i_data[int'(win_idx_s)*data_width +: data_width],
              bus.i_dest_y[int'(win_idx_s)*y_size +: y_size],
              bus.i_dest_x[int'(win_idx_s)*x_size +: x_size]};
    if (win_idx_s == ID_W'(N_SRC - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = win_idx_s + ID_W'(1);
    end
  end

  // One-hot accept strobe to the winning requester, only when loading.
  always_comb begin
    ready_s = '0;
    if (load_s && win_found_s) begin
      ready_s[win_idx_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  // Output buffer FSM: load on grant, hold while stalled, empty when drained with no request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
      valid_r <= 1'b0;
      data_r  <= '0;
      grant_r <= '0;
      ptr_r   <= '0;
    end else begin
      case (state_r)
        ST_EMPTY, ST_FULL: begin
          if (load_s && win_found_s) begin
            state_r <= ST_FULL;
            valid_r <= 1'b1;
            data_r  <= flit_s;
            grant_r <= win_idx_s;
            ptr_r   <= ptr_next_s;
          end else if (load_s) begin
            // Drained (or idle) with nobody requesting; last flit value is kept.
            state_r <= ST_EMPTY;
            valid_r <= 1'b0;
          end else begin
            // Stalled by the switch: everything holds.
            state_r <= state_r;
            valid_r <= valid_r;
          end
        end
        default: begin
          state_r <= ST_EMPTY;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready    = ready_s;
  assign bus.o_valid_pe = valid_r;
  assign bus.o_data_pe  = data_r;
  assign bus.o_grant_id = grant_r;

`ifdef NOC_INJ_STATS_EN
  logic [31:0] pkt_cnt_r;
  logic [31:0] stall_cnt_r;

  // Saturating counts of accepted flits and of switch-stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_r   <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      if (valid_r && bus.i_ready_pe && (pkt_cnt_r != 32'hFFFF_FFFF)) begin
        pkt_cnt_r <= pkt_cnt_r + 32'd1;
      end else begin
        pkt_cnt_r <= pkt_cnt_r;
      end
      if (valid_r && !bus.i_ready_pe && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign o_pkt_cnt   = pkt_cnt_r;
  assign o_stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_noc_pe_inject_arb.sv
// ---------------------------------------------------------------------------
// tb_noc_pe_inject_arb
// Directed bench for noc_pe_inject_arb. A queue-free behavioural model tracks
// the one-entry buffer and round-robin pointer as plain integers; a negedge
// process compares every DUT output with it each cycle, and the main sequence
// adds hand-computed literal expectations. Counter checks are compiled in
// when NOC_INJ_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_noc_pe_inject_arb;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int XS = 1;
  localparam int YS = 1;
  localparam int TW = XS + YS + DW;
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  noc_pe_inject_arb_if #(.N_SRC(N), .data_width(DW), .x_size(XS), .y_size(YS)) bus ();

`ifdef NOC_INJ_STATS_EN
  logic [31:0] pkt_cnt;
  logic [31:0] stall_cnt;
`endif

  noc_pe_inject_arb #(.N_SRC(N), .data_width(DW), .x_size(XS), .y_size(YS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef NOC_INJ_STATS_EN
    ,
    .o_pkt_cnt   (pkt_cnt),
    .o_stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  bit            m_valid = 1'b0;
  logic [TW-1:0] m_data  = '0;
  int            m_grant = 0;
  int            m_ptr   = 0;
  longint        m_pkt   = 0;
  longint        m_stall = 0;

  function automatic int win_of(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [TW-1:0] flit_of(input int k);
    return {bus.i_data[k*DW +: DW], bus.i_dest_y[k*YS +: YS], bus.i_dest_x[k*XS +: XS]};
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int w;
    r = '0;
    if (!rst && (!m_valid || bus.i_ready_pe)) begin
      w = win_of(bus.i_valid, m_ptr);
      if (w >= 0) r[w] = 1'b1;
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_grant <= 0;
      m_ptr   <= 0;
      m_pkt   <= 0;
      m_stall <= 0;
    end else begin
      if (m_valid && bus.i_ready_pe)  m_pkt   <= (m_pkt   >= 64'hFFFF_FFFF) ? m_pkt   : m_pkt + 1;
      if (m_valid && !bus.i_ready_pe) m_stall <= (m_stall >= 64'hFFFF_FFFF) ? m_stall : m_stall + 1;
      if (!m_valid || bus.i_ready_pe) begin
        if (win_of(bus.i_valid, m_ptr) >= 0) begin
          m_valid <= 1'b1;
          m_grant <= win_of(bus.i_valid, m_ptr);
          m_data  <= flit_of(win_of(bus.i_valid, m_ptr));
          m_ptr   <= (win_of(bus.i_valid, m_ptr) + 1) % N;
        end else begin
          m_valid <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("cmp_ready", 64'(bus.o_ready), 64'(exp_ready()));
    chk("cmp_valid", 64'(bus.o_valid_pe), 64'(m_valid));
    if (m_valid || rst) begin
      chk("cmp_data",  64'(bus.o_data_pe), 64'(m_data));
      chk("cmp_grant", 64'(bus.o_grant_id), 64'(m_grant));
    end
`ifdef NOC_INJ_STATS_EN
    chk("cmp_pkt",   64'(pkt_cnt),   64'(m_pkt));
    chk("cmp_stall", 64'(stall_cnt), 64'(m_stall));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst            = 1'b1;
    bus.i_valid    = 4'b1111;
    bus.i_ready_pe = 1'b1;
    for (int k = 0; k < N; k++) begin
      bus.i_data[k*DW +: DW]   = 32'hA000_0000 + k;
      bus.i_dest_x[k*XS +: XS] = k[0];
      bus.i_dest_y[k*YS +: YS] = k[1];
    end

    // Reset held with every requester valid.
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid", 64'(bus.o_valid_pe), 64'd0);
      chk("rst_ready", 64'(bus.o_ready), 64'd0);
      chk("rst_grant", 64'(bus.o_grant_id), 64'd0);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("first_ready", 64'(bus.o_ready), 64'h1);

    // All valid, switch always ready: 0,1,2,3,0,1,2,3.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_grant", 64'(bus.o_grant_id), 64'(i % 4));
      chk("rr_valid", 64'(bus.o_valid_pe), 64'd1);
    end
    tick();
    bus.i_valid = 4'b0000;
    tick();

    // Single requester 2 with a known payload and destination.
    bus.i_valid              = 4'b0100;
    bus.i_data[2*DW +: DW]   = 32'hDEAD_BEEF;
    bus.i_dest_x[2*XS +: XS] = 1'b1;
    bus.i_dest_y[2*YS +: YS] = 1'b0;
    @(negedge clk);
    chk("req2_ready", 64'(bus.o_ready), 64'h4);
    tick();
    bus.i_valid    = 4'b1001;
    bus.i_ready_pe = 1'b0;
    @(negedge clk);
    chk("req2_valid", 64'(bus.o_valid_pe), 64'd1);
    chk("req2_data",  64'(bus.o_data_pe), 64'({32'hDEAD_BEEF, 1'b0, 1'b1}));
    chk("req2_grant", 64'(bus.o_grant_id), 64'd2);

    // Stall: flit holds, nobody is strobed.
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("stall_ready", 64'(bus.o_ready), 64'd0);
      chk("stall_data",  64'(bus.o_data_pe), 64'({32'hDEAD_BEEF, 1'b0, 1'b1}));
    end

    // Release: pointer sits at 3, so req3 wins ahead of req0, then wrap to req0.
    tick();
    bus.i_ready_pe = 1'b1;
    @(negedge clk);
    chk("wrap_ready3", 64'(bus.o_ready), 64'h8);
    tick();
    bus.i_valid = 4'b0001;
    @(negedge clk);
    chk("wrap_grant3", 64'(bus.o_grant_id), 64'd3);
    chk("wrap_ready0", 64'(bus.o_ready), 64'h1);
    tick();
    bus.i_valid = 4'b0000;
    @(negedge clk);
    chk("wrap_grant0", 64'(bus.o_grant_id), 64'd0);
    tick();

    // Fresh reset, then 10 sends and 4 stall cycles, then reset mid-stall.
    rst = 1'b1;
    tick();
    rst            = 1'b0;
    bus.i_valid    = 4'b0010;
    bus.i_ready_pe = 1'b1;
    repeat (10) tick();
    bus.i_valid = 4'b0000;
    tick();
    bus.i_valid    = 4'b0010;
    bus.i_ready_pe = 1'b0;
    tick();
    bus.i_valid = 4'b0000;
    repeat (4) tick();
    @(negedge clk);
    chk("stall_hold_valid", 64'(bus.o_valid_pe), 64'd1);
`ifdef NOC_INJ_STATS_EN
    chk("pkt_cnt10",  64'(pkt_cnt),   64'd10);
    chk("stall_cnt4", 64'(stall_cnt), 64'd4);
`endif
    #2;
    rst            = 1'b1;
    bus.i_ready_pe = 1'b1;
    bus.i_valid    = 4'b0010;
    #1;
    chk("arst_valid", 64'(bus.o_valid_pe), 64'd0);
    chk("arst_ready", 64'(bus.o_ready), 64'd0);
    chk("arst_data",  64'(bus.o_data_pe), 64'd0);
`ifdef NOC_INJ_STATS_EN
    chk("arst_pkt",   64'(pkt_cnt),   64'd0);
    chk("arst_stall", 64'(stall_cnt), 64'd0);
`endif
    tick();
    rst         = 1'b0;
    bus.i_valid = 4'b0000;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
